input_packet_gate: RTL and testbench
====================================

INPUT_PACKET_GATE -- requirements
Module: input_packet_gate

Interface
REQ-001 Parameter DEPTH_LOG2, default 6, log2 of the packet store depth in 256-bit words (64 words).
REQ-002 clk  input  1  framework clock (axi_aclk domain); sole clock of the block.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 s_axis_tdata  input  256  beat data from the async width converter.
REQ-005 s_axis_tkeep  input  32  byte enables, contiguous from bit 0.
REQ-006 s_axis_tuser  input  1  MAC bad-frame flag; sampled on the tlast beat.
REQ-007 s_axis_tvalid  input  1  beat valid.
REQ-008 s_axis_tready  output  1  beat accept; never backpressures during normal operation.
REQ-009 s_axis_tlast  input  1  last beat of packet.
REQ-010 error  input  1  converter overflow pulse: the current or next packet is corrupt.
REQ-011 must_read  input  1  converter almost-full; monitored only, since the gate never stalls.
REQ-012 m_axis_tdata/m_axis_tkeep/m_axis_tlast  output  256/32/1  committed packet stream.
REQ-013 m_axis_tvalid  output  1 / m_axis_tready  input  1  AXI4-Stream handshake.
REQ-014 drop_count  output  16  saturating count of discarded packets.
REQ-015 pkt_count  output  16  wrapping count of committed packets.

Function
REQ-016 A beat is accepted when s_axis_tvalid and s_axis_tready are both 1; s_axis_tready SHALL be 1 in every cycle outside reset.
REQ-017 The write side SHALL be a three-state FSM: IDLE (no packet open), WRITE (packet being stored), DROP (discard until tlast).
REQ-018 The store SHALL use a write pointer wr_ptr, a commit pointer cm_ptr and a read pointer rd_ptr, each DEPTH_LOG2+1 bits wide and wrapping modulo 2^(DEPTH_LOG2+1).
REQ-019 The store is full when wr_ptr - rd_ptr == 2^DEPTH_LOG2.
REQ-020 IDLE or WRITE, beat accepted, store not full, err_pending 0: write the beat at wr_ptr and increment wr_ptr.
  - Without tlast, the FSM goes to WRITE.
  - With tlast and tuser 0, set cm_ptr to the new wr_ptr, increment pkt_count and go to IDLE.
  - With tlast and tuser 1, rewind wr_ptr to cm_ptr, increment drop_count and go to IDLE.
REQ-021 Beat accepted while the store is full or err_pending is 1: rewind wr_ptr to cm_ptr.
  - Without tlast, go to DROP.
  - With tlast, go to IDLE.
  - Increment drop_count exactly once per packet either way.
REQ-022 DROP: discard beats and write nothing; on the tlast beat go to IDLE and clear err_pending.
REQ-023 err_pending SHALL be set in the cycle after error is 1, and cleared on the tlast beat of the packet it drops.
  - If error and a tlast beat coincide, the current packet is dropped and err_pending is not left set.
REQ-024 Packets longer than 2^DEPTH_LOG2 beats SHALL always be dropped by the full rule; no deadlock results.
REQ-025 The read side SHALL present only committed words (rd_ptr != cm_ptr).
  - RAM read latency is 1 cycle, followed by a 2-entry output stage, so full throughput is sustained.
REQ-026 Latency: with the output idle, the first output beat SHALL be valid 2 cycles after the committing tlast beat is accepted.
REQ-027 m_axis_* outputs SHALL hold stable while m_axis_tvalid is 1 and m_axis_tready is 0.
REQ-028 A beat is never lost or duplicated; packet order is preserved.
REQ-029 Simultaneous commit and read in one cycle SHALL both take effect.
REQ-030 A rewind in the same cycle as a read SHALL not disturb rd_ptr.
REQ-031 drop_count SHALL hold at 16'hFFFF once reached; pkt_count SHALL wrap to 0.

Reset
REQ-032 During reset, all pointers, err_pending, drop_count and pkt_count SHALL be 0 and the FSM SHALL be IDLE.
REQ-033 During reset, m_axis_tvalid and s_axis_tready SHALL be 0 and m_axis_tdata/tkeep/tlast SHALL be 0.
REQ-034 Reset asserted mid-packet SHALL discard all stored and partial data.
  - After reset release, a continuation of that packet is treated as a new packet.

Structure
REQ-035 The shared nf10_upb_lib package holds:
  - constants AXIS_DATA_W=256 and AXIS_KEEP_W=32;
  - the FSM state encoding (IDLE, WRITE, DROP);
  - the 289-bit store word layout {tlast, tkeep, tdata}.
REQ-036 One sub-module, sdp_ram (simple dual-port, one write and one registered read port, parameterised width and depth), holds the store.

Verification
REQ-037 Two 2-beat packets, tuser 0, m_axis_tready 1 -> 4 output beats identical to the input; pkt_count=2; first output 2 cycles after the first tlast.
REQ-038 A 3-beat packet with tuser=1 on tlast, then a 1-beat good packet -> only the 1-beat packet is output; drop_count=1; pkt_count=1.
REQ-039 error pulsed while idle, then a 2-beat packet, then a 2-beat packet -> the first is dropped and the second is output; drop_count=1.
REQ-040 m_axis_tready 0, 70 single-beat good packets -> 64 stored; 6 dropped (drop_count=6); releasing tready outputs 64 packets in order.
REQ-041 A 65-beat packet with DEPTH_LOG2=6 -> dropped; the next 1-beat packet is output normally; s_axis_tready stays 1 throughout.
REQ-042 Reset on beat 2 of a 4-beat packet, then beats 3-4 -> nothing is output; pkt_count=0; all outputs are 0 during reset.

Source files
------------

// File: rtl/nf10_upb_lib_pkg.sv
// Shared definitions for the input packet gate: AXI-Stream widths,
// write-side FSM encoding and the packed layout of one store word.
package nf10_upb_lib;

  localparam int AXIS_DATA_W = 32'd256;
  localparam int AXIS_KEEP_W = 32'd32;
  localparam int STORE_W     = 32'd1 + AXIS_KEEP_W + AXIS_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic                   tlast;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic [AXIS_DATA_W-1:0] tdata;
  } store_word_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port and one read port
// whose data appears one clock after the read enable.
module sdp_ram #(
  parameter int WIDTH      = 32'd8,
  parameter int DEPTH_LOG2 = 32'd4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 32'd1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // write port plus registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/input_packet_gate.sv
// Store-and-forward gate: whole packets are buffered and only released once
// their tlast arrives clean; bad, overflowing or oversized packets are discarded.
module input_packet_gate
  import nf10_upb_lib::*;
#(
  parameter int DEPTH_LOG2 = 32'd6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   error,
  input  logic                   must_read,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [15:0]            drop_count,
  output logic [15:0]            pkt_count
);

  localparam int PW = DEPTH_LOG2 + 32'd1;
  localparam logic [PW-1:0] ONE      = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [PW-1:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};

  wr_state_e   state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, fe_ptr_q, fe_ptr_d;
  logic        err_pending_q, err_pending_d;
  logic [15:0] drop_count_q, drop_count_d, pkt_count_q, pkt_count_d;
  logic        tready_q;
  logic        rv_q, rv_d;
  store_word_t head_q, head_d, skid_q, skid_d;
  logic        head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;

  logic        accept_s, full_s, corrupt_s, pop_s, ram_we_s, ram_re_s;
  logic [2:0]  inflight_s;
  store_word_t ram_wdata_s, ram_rdata_s;
  logic        unused_must_read_s;

  assign unused_must_read_s = must_read;

  sdp_ram #(
    .WIDTH      (STORE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_store (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .raddr (fe_ptr_q[DEPTH_LOG2-1:0]),
    .rdata (ram_rdata_s)
  );

  // rd_ptr frees store space only when a word leaves the output stage;
  // fe_ptr runs ahead of it to prefetch committed words into that stage.
  always_comb begin
    accept_s    = s_axis_tvalid & tready_q;
    full_s      = ((wr_ptr_q - rd_ptr_q) == CAPACITY);
    corrupt_s   = err_pending_q | (error & s_axis_tlast);
    pop_s       = head_valid_q & m_axis_tready;
    inflight_s  = {2'b00, head_valid_q} + {2'b00, skid_valid_q} + {2'b00, rv_q} - {2'b00, pop_s};
    ram_re_s    = (fe_ptr_q != cm_ptr_q) && (inflight_s <= 3'd1);
    ram_we_s    = 1'b0;
    ram_wdata_s = '{tlast: s_axis_tlast, tkeep: s_axis_tkeep, tdata: s_axis_tdata};

    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cm_ptr_d      = cm_ptr_q;
    drop_count_d  = drop_count_q;
    pkt_count_d   = pkt_count_q;
    rd_ptr_d      = pop_s ? rd_ptr_q + ONE : rd_ptr_q;
    fe_ptr_d      = ram_re_s ? fe_ptr_q + ONE : fe_ptr_q;
    rv_d          = ram_re_s;
    head_d        = head_q;
    head_valid_d  = head_valid_q;
    skid_d        = skid_q;
    skid_valid_d  = skid_valid_q;

    case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (accept_s && (full_s || corrupt_s)) begin
          wr_ptr_d     = cm_ptr_q;
          drop_count_d = sat_inc16(drop_count_q);
          state_d      = s_axis_tlast ? ST_IDLE : ST_DROP;
        end else if (accept_s) begin
          ram_we_s = 1'b1;
          if (!s_axis_tlast) begin
            wr_ptr_d = wr_ptr_q + ONE;
            state_d  = ST_WRITE;
          end else if (s_axis_tuser) begin
            wr_ptr_d     = cm_ptr_q;
            drop_count_d = sat_inc16(drop_count_q);
            state_d      = ST_IDLE;
          end else begin
            wr_ptr_d    = wr_ptr_q + ONE;
            cm_ptr_d    = wr_ptr_q + ONE;
            pkt_count_d = pkt_count_q + 16'd1;
            state_d     = ST_IDLE;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DROP: begin
        if (accept_s && s_axis_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept_s && s_axis_tlast) begin
      err_pending_d = 1'b0;
    end else if (error) begin
      err_pending_d = 1'b1;
    end else begin
      err_pending_d = err_pending_q;
    end

    case ({pop_s, rv_q})
      2'b01: begin
        if (!head_valid_q) begin
          head_d       = ram_rdata_s;
          head_valid_d = 1'b1;
        end else begin
          skid_d       = ram_rdata_s;
          skid_valid_d = 1'b1;
        end
      end
      2'b10: begin
        if (skid_valid_q) begin
          head_d       = skid_q;
          skid_valid_d = 1'b0;
        end else begin
          head_valid_d = 1'b0;
        end
      end
      2'b11: begin
        if (skid_valid_q) begin
          head_d = skid_q;
          skid_d = ram_rdata_s;
        end else begin
          head_d = ram_rdata_s;
        end
      end
      default: head_d = head_q;
    endcase
  end

  // state, pointer, counter and output-stage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      cm_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fe_ptr_q      <= '0;
      err_pending_q <= 1'b0;
      drop_count_q  <= 16'd0;
      pkt_count_q   <= 16'd0;
      tready_q      <= 1'b0;
      rv_q          <= 1'b0;
      head_q        <= '0;
      head_valid_q  <= 1'b0;
      skid_q        <= '0;
      skid_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cm_ptr_q      <= cm_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fe_ptr_q      <= fe_ptr_d;
      err_pending_q <= err_pending_d;
      drop_count_q  <= drop_count_d;
      pkt_count_q   <= pkt_count_d;
      tready_q      <= 1'b1;
      rv_q          <= rv_d;
      head_q        <= head_d;
      head_valid_q  <= head_valid_d;
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = head_valid_q;
  assign m_axis_tdata  = head_q.tdata;
  assign m_axis_tkeep  = head_q.tkeep;
  assign m_axis_tlast  = head_q.tlast;
  assign drop_count    = drop_count_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_input_packet_gate.sv
// Randomised bench for input_packet_gate: a queue-based packet model predicts
// committed beats and counters; directed scenarios pin the model with literals.
module tb_input_packet_gate;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic         s_axis_tuser, s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic         error, must_read;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic         m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [15:0]  drop_count, pkt_count;

  always #5 clk = ~clk;

  input_packet_gate #(.DEPTH_LOG2(6)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .error(error), .must_read(must_read),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .drop_count(drop_count), .pkt_count(pkt_count)
  );

  int checks = 0;
  int errors = 0;

  // model state: committed-but-not-output beats, and the open packet
  beat_t       exp_q[$];
  beat_t       part_q[$];
  int          m_drop;
  logic [15:0] m_pkt;
  bit          m_dropping, m_errp, exp_tready, last_rst, started, prev_stall;
  beat_t       prev_out;
  int          out_cnt = 0;

  bit fixed_ready = 1'b1;
  bit rand_ready  = 1'b0;
  int ready_pct   = 50;

  task automatic chk(input string name, input logic [288:0] act, input logic [288:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // compare process: check outputs, then advance the model to the next edge
  always @(negedge clk) begin
    beat_t cur, fr, nb;
    bit full, beat;
    cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    if (started) begin
      chk("s_axis_tready", {288'd0, s_axis_tready}, {288'd0, exp_tready});
      chk("drop_count", {273'd0, drop_count}, {273'd0, m_drop[15:0]});
      chk("pkt_count", {273'd0, pkt_count}, {273'd0, m_pkt});
      if (last_rst) begin
        chk("reset_tvalid", {288'd0, m_axis_tvalid}, 289'd0);
        chk("reset_outputs", cur, 289'd0);
      end
      if (prev_stall && !last_rst) begin
        chk("hold_tvalid", {288'd0, m_axis_tvalid}, 289'd1);
        chk("hold_beat", cur, prev_out);
      end
    end
    prev_stall = started && !reset && m_axis_tvalid && !m_axis_tready;
    prev_out   = cur;
    if (reset) begin
      exp_q.delete();
      part_q.delete();
      m_drop = 0; m_pkt = 16'd0; m_dropping = 1'b0; m_errp = 1'b0;
      started = 1'b1; last_rst = 1'b1; exp_tready = 1'b0;
    end else begin
      last_rst = 1'b0;
      full = (exp_q.size() + part_q.size()) == 64;
      if (started && m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_beat: got %0h expected no beat", cur);
        end else begin
          fr = exp_q.pop_front();
          chk("out_beat", cur, fr);
          out_cnt++;
        end
      end
      beat = s_axis_tvalid && exp_tready;
      if (beat) begin
        nb = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
        if (m_dropping) begin
          if (s_axis_tlast) m_dropping = 1'b0;
        end else if (full || m_errp || (error && s_axis_tlast)) begin
          part_q.delete();
          if (m_drop < 65535) m_drop++;
          m_dropping = !s_axis_tlast;
        end else begin
          part_q.push_back(nb);
          if (s_axis_tlast) begin
            if (s_axis_tuser) begin
              if (m_drop < 65535) m_drop++;
            end else begin
              foreach (part_q[i]) exp_q.push_back(part_q[i]);
              m_pkt = m_pkt + 16'd1;
            end
            part_q.delete();
          end
        end
      end
      if (beat && s_axis_tlast) m_errp = 1'b0;
      else if (error) m_errp = 1'b1;
      exp_tready = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m_axis_tready = rand_ready ? ($urandom_range(0, 99) < ready_pct) : fixed_ready;
  endtask

  task automatic send(input logic [255:0] d, input logic [31:0] k, input logic l,
                      input logic u, input logic e);
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k;
    s_axis_tlast = l; s_axis_tuser = u; error = e;
    tick();
  endtask

  task automatic idle(input int n, input bit err_en);
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      error = err_en && ($urandom_range(0, 29) == 0);
      tick();
    end
    error = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; s_axis_tvalid = 1'b0; error = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    rand_ready = 1'b0; fixed_ready = 1'b1;
    idle(1, 1'b0);
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    idle(3, 1'b0);
  endtask

  function automatic logic [255:0] rand_data();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [31:0] mkkeep(input int n);
    logic [32:0] t;
    t = (33'd1 << n) - 33'd1;
    return t[31:0];
  endfunction

  initial begin
    int base;
    logic [255:0] d0;
    reset = 1'b1; must_read = 1'b0; error = 1'b0; m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // two good 2-beat packets, first-output latency
    do_reset();
    base = out_cnt;
    d0 = 256'hA0A0_0001;
    send(d0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    send(256'hA0A0_0002, 32'h0000_00FF, 1'b1, 1'b0, 1'b0);
    chk("latency_e0", {288'd0, m_axis_tvalid}, 289'd0);
    send(256'hB0B0_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    chk("latency_e1", {288'd0, m_axis_tvalid}, 289'd0);
    send(256'hB0B0_0002, 32'h0000_000F, 1'b1, 1'b0, 1'b0);
    chk("latency_e2", {288'd0, m_axis_tvalid}, 289'd1);
    chk("first_data", {33'd0, m_axis_tdata}, {33'd0, d0});
    drain(100);
    chk("t1_pkt_count", {273'd0, pkt_count}, 289'd2);
    chk("t1_out_beats", out_cnt - base, 289'd4);

    // tuser-marked bad packet then a good single beat
    do_reset();
    base = out_cnt;
    send(256'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    send(256'h2, 32'h1, 1'b0, 1'b0, 1'b0);
    send(256'h3, 32'h1, 1'b1, 1'b1, 1'b0);
    send(256'h4, 32'h3, 1'b1, 1'b0, 1'b0);
    drain(100);
    chk("t2_drop_count", {273'd0, drop_count}, 289'd1);
    chk("t2_pkt_count", {273'd0, pkt_count}, 289'd1);
    chk("t2_out_beats", out_cnt - base, 289'd1);

    // error pulse while idle corrupts the next packet only
    do_reset();
    base = out_cnt;
    s_axis_tvalid = 1'b0; error = 1'b1;
    tick();
    send(256'h11, 32'h1, 1'b0, 1'b0, 1'b0);
    send(256'h12, 32'h1, 1'b1, 1'b0, 1'b0);
    send(256'h21, 32'h1, 1'b0, 1'b0, 1'b0);
    send(256'h22, 32'h1, 1'b1, 1'b0, 1'b0);
    drain(100);
    chk("t3_drop_count", {273'd0, drop_count}, 289'd1);
    chk("t3_out_beats", out_cnt - base, 289'd2);

    // 70 single-beat packets into a stalled output
    do_reset();
    base = out_cnt;
    fixed_ready = 1'b0;
    for (int i = 0; i < 70; i++) send(256'(i + 1000), 32'hF, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t4_drop_count", {273'd0, drop_count}, 289'd6);
    chk("t4_pkt_count", {273'd0, pkt_count}, 289'd64);
    chk("t4_no_output", out_cnt - base, 289'd0);
    drain(300);
    chk("t4_out_beats", out_cnt - base, 289'd64);

    // oversized packet is dropped by the full rule
    do_reset();
    base = out_cnt;
    for (int i = 1; i <= 65; i++) send(rand_data(), 32'hFFFF_FFFF, i == 65, 1'b0, 1'b0);
    send(256'h77, 32'h1, 1'b1, 1'b0, 1'b0);
    drain(100);
    chk("t5_drop_count", {273'd0, drop_count}, 289'd1);
    chk("t5_pkt_count", {273'd0, pkt_count}, 289'd1);
    chk("t5_out_beats", out_cnt - base, 289'd1);

    // reset in the middle of a packet discards stored and partial data
    do_reset();
    base = out_cnt;
    fixed_ready = 1'b0;
    send(256'h55, 32'h1, 1'b1, 1'b0, 1'b0);
    send(256'h61, 32'h1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    send(256'h62, 32'h1, 1'b0, 1'b0, 1'b0);
    chk("t6_tvalid_in_reset", {288'd0, m_axis_tvalid}, 289'd0);
    send(256'h63, 32'h1, 1'b0, 1'b0, 1'b0);
    send(256'h64, 32'h1, 1'b1, 1'b0, 1'b0);
    chk("t6_tdata_in_reset", {33'd0, m_axis_tdata}, 289'd0);
    reset = 1'b0;
    fixed_ready = 1'b1;
    idle(10, 1'b0);
    chk("t6_pkt_count", {273'd0, pkt_count}, 289'd0);
    chk("t6_out_beats", out_cnt - base, 289'd0);

    // randomised traffic with varying backpressure and error pulses
    do_reset();
    rand_ready = 1'b1;
    for (int p = 0; p < 240; p++) begin
      int len, r;
      case (p / 40)
        0: ready_pct = 90;
        1: ready_pct = 20;
        2: ready_pct = 60;
        3: ready_pct = 5;
        4: ready_pct = 100;
        default: ready_pct = 50;
      endcase
      r = $urandom_range(0, 99);
      len = (r < 70) ? $urandom_range(1, 4) : (r < 95) ? $urandom_range(5, 20) : $urandom_range(60, 70);
      for (int b = 1; b <= len; b++) begin
        send(rand_data(), mkkeep($urandom_range(1, 32)), b == len,
             $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
        if ($urandom_range(0, 4) == 0) idle(1, 1'b1);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 1'b1);
    end
    drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
